// File: rtl/line_doubler_buf.sv
// Double-buffered 320-pixel scanline store feeding a 640-pixel VGA line buffer.
// Each source pixel and each source line is shown twice (320x240 -> 640x480).
module line_doubler_buf #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int VIS_H = 480
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [8:0]                        line_number,
  input  logic [11:0]                       pix_data,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  output logic                              line_req,
  output logic [7:0]                        line_req_num,
  output logic [2*SRC_W-1:0][2:0][3:0]      lbuffer,
  output logic                              underrun
);

  localparam int PW = $clog2(SRC_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          front_sel_q, front_sel_d;
  logic          back_full_q, back_full_d;
  logic [7:0]    back_line_q, back_line_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    next_line_q, next_line_d;
  logic [8:0]    prev_ln_q, prev_ln_d;
  logic          line_req_q, line_req_d;
  logic [7:0]    line_req_num_q, line_req_num_d;
  logic          underrun_q, underrun_d;

  logic          swap_ev;
  logic [7:0]    s_line;
  logic [7:0]    s_next;
  logic          wr_en;

  always_comb begin
    s_line  = line_number[8:1];
    s_next  = (s_line == 8'(SRC_H - 1)) ? 8'd0 : s_line + 8'd1;
    swap_ev = (line_number != prev_ln_q) && (line_number < 9'(VIS_H)) && !line_number[0];
    // A swap in the same cycle as a pixel beat wins; that pixel is dropped.
    wr_en   = pix_valid && (state_q == ST_FILL) && !swap_ev;
  end

  always_comb begin
    state_d        = state_q;
    front_sel_d    = front_sel_q;
    back_full_d    = back_full_q;
    back_line_d    = back_line_q;
    wr_ptr_d       = wr_ptr_q;
    next_line_d    = next_line_q;
    prev_ln_d      = line_number;
    line_req_d     = 1'b0;
    line_req_num_d = line_req_num_q;
    underrun_d     = underrun_q;

    if (swap_ev) begin
      if (back_full_q && (back_line_q == s_line)) begin
        front_sel_d = ~front_sel_q;
      end else begin
        underrun_d = 1'b1;
      end
      back_full_d = 1'b0;
      wr_ptr_d    = '0;
      next_line_d = s_next;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          line_req_d     = 1'b1;
          line_req_num_d = next_line_q;
          back_line_d    = next_line_q;
          wr_ptr_d       = '0;
          state_d        = ST_FILL;
        end
        ST_FILL: begin
          if (pix_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == PW'(SRC_W - 1)) begin
              back_full_d = 1'b1;
              state_d     = ST_READY;
            end
          end
        end
        ST_READY: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      front_sel_q    <= 1'b0;
      back_full_q    <= 1'b0;
      back_line_q    <= 8'd0;
      wr_ptr_q       <= '0;
      next_line_q    <= 8'd0;
      prev_ln_q      <= 9'h1FF;
      line_req_q     <= 1'b0;
      line_req_num_q <= 8'd0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      back_full_q    <= back_full_d;
      back_line_q    <= back_line_d;
      wr_ptr_q       <= wr_ptr_d;
      next_line_q    <= next_line_d;
      prev_ln_q      <= prev_ln_d;
      line_req_q     <= line_req_d;
      line_req_num_q <= line_req_num_d;
      underrun_q     <= underrun_d;
    end
  end

  assign pix_ready    = (state_q == ST_FILL);
  assign line_req     = line_req_q;
  assign line_req_num = line_req_num_q;
  assign underrun     = underrun_q;

  // Per-pixel storage is flops: the whole front line is read in parallel.
  genvar gi;
  generate
    for (gi = 0; gi < SRC_W; gi++) begin : g_pix
      localparam logic [PW-1:0] IDX = PW'(gi);
      logic        hit;
      logic [11:0] b0_q, b0_d, b1_q, b1_d;

      always_comb begin
        hit  = wr_en && (wr_ptr_q == IDX);
        b0_d = (hit && front_sel_q)  ? pix_data : b0_q;
        b1_d = (hit && !front_sel_q) ? pix_data : b1_q;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          b0_q <= 12'd0;
          b1_q <= 12'd0;
        end else begin
          b0_q <= b0_d;
          b1_q <= b1_d;
        end
      end

      assign lbuffer[2*gi]   = front_sel_q ? b1_q : b0_q;
      assign lbuffer[2*gi+1] = front_sel_q ? b1_q : b0_q;
    end
  endgenerate

endmodule

// File: tb/tb_line_doubler_buf.sv
// Randomized bench for line_doubler_buf against a line-level reference model
// (front/back line arrays, fill count and request bookkeeping).
module tb_line_doubler_buf;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [8:0]                 line_number = 9'd500;
  logic [11:0]                pix_data = 12'd0;
  logic                       pix_valid = 1'b0;
  logic                       pix_ready;
  logic                       line_req;
  logic [7:0]                 line_req_num;
  logic [639:0][2:0][3:0]     lbuffer;
  logic                       underrun;

  line_doubler_buf dut (
    .clk          (clk),
    .reset        (reset),
    .line_number  (line_number),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .line_req     (line_req),
    .line_req_num (line_req_num),
    .lbuffer      (lbuffer),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the VGA side sees, what is being assembled, and
  // which source line is owed next.
  int m_front[320];
  int m_back[320];
  int m_fill;        // pixels accepted into the line under construction
  int m_phase;       // 0 = must request, 1 = accepting pixels, 2 = line complete
  int m_back_line;
  int m_next;
  int m_prev;
  int m_req;
  int m_req_num;
  int m_under;
  int data_mode = 0; // 1: pixel value equals its index in the line

  task automatic m_reset();
    for (int k = 0; k < 320; k++) begin
      m_front[k] = 0;
      m_back[k]  = 0;
    end
    m_fill = 0; m_phase = 0; m_back_line = 0; m_next = 0;
    m_prev = 511; m_req = 0; m_req_num = 0; m_under = 0;
  endtask

  task automatic model_step();
    int ln;
    int s;
    bit ev;
    ln = int'(line_number);
    s  = ln / 2;
    ev = (ln != m_prev) && (ln < 480) && (ln % 2 == 0);
    m_prev = ln;
    m_req  = 0;
    if (ev) begin
      if (m_phase == 2 && m_back_line == s) m_front = m_back;
      else m_under = 1;
      m_phase = 0;
      m_fill  = 0;
      m_next  = (s + 1) % 240;
    end else if (m_phase == 0) begin
      m_req = 1;
      m_req_num = m_next;
      m_back_line = m_next;
      m_fill = 0;
      m_phase = 1;
    end else if (m_phase == 1 && pix_valid) begin
      m_back[m_fill] = int'(pix_data);
      m_fill++;
      if (m_fill == 320) m_phase = 2;
    end
  endtask

  task automatic check_outputs();
    int bad;
    int idx;
    bad = 0;
    for (int k = 0; k < 640; k++)
      if (lbuffer[k] !== 12'(m_front[k/2])) bad++;
    check("pix_ready", pix_ready, (m_phase == 1));
    check("line_req", line_req, m_req);
    check("line_req_num", line_req_num, m_req_num);
    check("underrun", underrun, m_under);
    check("lbuf_bad_pixels", bad, 0);
    idx = $urandom_range(0, 639);
    check("lbuf_px", lbuffer[idx], m_front[idx/2]);
  endtask

  // One clock: entered and left on a falling edge.
  task automatic cycle(input int ln, input int valid_pct);
    check_outputs();
    line_number = 9'(ln);
    pix_valid   = ($urandom_range(0, 99) < valid_pct);
    if (data_mode == 1 && m_phase == 1) pix_data = 12'(m_fill);
    else pix_data = 12'($urandom_range(0, 4095));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int ln, input int n, input int valid_pct);
    for (int i = 0; i < n; i++) cycle(ln, valid_pct);
  endtask

  task automatic do_reset(input int ln);
    int nz;
    reset = 1'b0;
    line_number = 9'(ln);
    pix_valid = 1'b0;
    #1;
    nz = 0;
    for (int k = 0; k < 640; k++)
      if (lbuffer[k] !== 12'd0) nz++;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_line_req", line_req, 0);
    check("rst_underrun", underrun, 0);
    check("rst_lbuf_nonzero", nz, 0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int ln;
    int r;
    m_reset();
    @(negedge clk);
    do_reset(500);

    // Line 0 with pixel value = index, then swap it in.
    data_mode = 1;
    run(500, 330, 100);
    data_mode = 0;
    run(0, 1, 100);
    check("swap0_px0", lbuffer[0], 12'h000);
    check("swap0_px1", lbuffer[1], 12'h000);
    check("swap0_px638", lbuffer[638], 12'h13F);
    check("swap0_px639", lbuffer[639], 12'h13F);
    run(0, 1, 100);
    check("req_after_swap0", line_req, 1);
    check("req_num_after_swap0", line_req_num, 1);

    // Fill line 1, odd line repeats, valid while full is ignored, swap at 2.
    run(0, 330, 100);
    run(1, 20, 100);
    run(2, 2, 100);
    // Line 2 only half filled when line 4 arrives.
    run(2, 160, 100);
    run(3, 5, 100);
    run(4, 3, 100);
    check("underrun_sticky", underrun, 1);

    // Wrap: source line 239 at VGA line 478, line 0 fills during blanking.
    run(476, 330, 100);
    run(477, 4, 100);
    run(478, 4, 100);
    for (int i = 0; i < 32; i++) run(480 + i, 12, 100);
    run(0, 4, 100);

    // Reset in the middle of a fill.
    do_reset(500);
    run(500, 101, 100);
    do_reset(500);
    run(500, 330, 80);
    run(500, 120, 80);
    run(0, 4, 80);

    // Random walk over VGA lines, with stalls and jumps.
    ln = 0;
    for (int step = 0; step < 100; step++) begin
      r = $urandom_range(0, 9);
      if (r < 7) ln = ln + 1;
      else if (r < 9) ln = ln + 2 * $urandom_range(1, 4);
      else ln = $urandom_range(0, 511);
      ln = ln % 512;
      run(ln, $urandom_range(20, 400), $urandom_range(40, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
